// File: rtl/ts_table_mux_pkg.sv
// Shared constants and FSM encoding for the PSI table / T2-MI TS merger.
package ts_table_mux_pkg;
  localparam int          PKT_LEN_DEF = 188;
  localparam logic [7:0]  TS_SYNC     = 8'h47;
  localparam logic [12:0] NULL_PID    = 13'h1FFF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND_MAIN = 3'd1,
    ST_SEND_TBL  = 3'd2,
    ST_GUARD     = 3'd3
  } state_t;

  // PID from TS header bytes 1 and 2
  function automatic logic [12:0] ts_pid(input logic [7:0] b1, input logic [7:0] b2);
    return {b1[4:0], b2};
  endfunction
endpackage

// File: rtl/ts_byte_fifo_ram.sv
// Simple dual-port byte RAM, 2^AW x 8, one write port, registered read port.
module ts_byte_fifo_ram #(
  parameter int AW = 10
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [0:(1<<AW)-1];

  // write port plus one-cycle registered read
  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/ts_table_mux.sv
// Merges inserter table packets into the main TS stream at packet boundaries.
// Main packets are staged in a byte FIFO and only become readable once all
// PKT_LEN bytes have arrived (commit_ptr). Optional build macro NULL_DROP_EN
// discards main packets carrying the null PID instead of buffering them.
module ts_table_mux
  import ts_table_mux_pkg::*;
#(
  parameter int FIFO_AW = 10,
  parameter int PKT_LEN = PKT_LEN_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  IN_DATA,
  input  logic        IN_ENA,
  input  logic        IN_PSYNC,
  input  logic        TABLE_READY,
  output logic        TBL_START,
  input  logic [7:0]  TBL_DATA,
  input  logic        TBL_ENA,
  input  logic        TBL_PSYNC,
  input  logic        TBL_SENT,
  output logic [7:0]  DATA_OUT,
  output logic        ENA_OUT,
  output logic        PSYNC_OUT,
  output logic [15:0] DROP_CNT,
  output logic [2:0]  state_mon
);
  localparam int IDX_W = $clog2(PKT_LEN + 1);
  localparam logic [FIFO_AW:0] DEPTH   = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0] PTR_ONE = (FIFO_AW+1)'(1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [FIFO_AW:0]   wr_ptr, commit_ptr, rd_ptr, pkt_count;
  logic [IDX_W-1:0]   byte_idx, rd_cnt;
  logic               in_active, discard;
  state_t             state;
  logic               rd_vld, rd_first;
  logic [7:0]         rd_data;

  logic               pkt_start, early, room, ram_we, last_byte, do_commit, rd_done;
  logic [FIFO_AW:0]   free_sp;
  logic [FIFO_AW-1:0] ram_waddr;
  logic [1:0]         drop_inc;
  logic [16:0]        drop_sum;

  // Space check uses committed data only: an aborted packet's bytes are reclaimed.
  assign free_sp   = DEPTH - (commit_ptr - rd_ptr);
  assign room      = free_sp >= (FIFO_AW+1)'(PKT_LEN);
  assign pkt_start = IN_ENA && IN_PSYNC;
  assign early     = pkt_start && in_active;
  assign ram_we    = (pkt_start && room) || (IN_ENA && !IN_PSYNC && in_active);
  assign ram_waddr = pkt_start ? commit_ptr[FIFO_AW-1:0] : wr_ptr[FIFO_AW-1:0];
  assign last_byte = IN_ENA && !IN_PSYNC && in_active && (byte_idx == IDX_W'(PKT_LEN-1));
  assign do_commit = last_byte && !discard;
  assign rd_done   = (state == ST_SEND_MAIN) && (rd_cnt == IDX_W'(PKT_LEN));
  assign drop_inc  = 2'(early) + 2'(pkt_start && !room);
  assign drop_sum  = {1'b0, DROP_CNT} + 17'(drop_inc);
  assign state_mon = state;

  ts_byte_fifo_ram #(.AW(FIFO_AW)) u_ram (
    .CLK   (CLK),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (IN_DATA),
    .raddr (rd_ptr[FIFO_AW-1:0]),
    .rdata (rd_data)
  );

  // Input writer: accept/drop at packet start, rewind on abort, commit on last byte
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      byte_idx   <= '0;
      in_active  <= 1'b0;
      DROP_CNT   <= '0;
    end else begin
      if (pkt_start) begin
        if (room) begin
          wr_ptr    <= commit_ptr + PTR_ONE;
          byte_idx  <= IDX_ONE;
          in_active <= 1'b1;
        end else begin
          wr_ptr    <= commit_ptr;
          in_active <= 1'b0;
        end
      end else if (IN_ENA && in_active) begin
        if (last_byte) begin
          in_active <= 1'b0;
          if (discard) begin
            wr_ptr <= commit_ptr;
          end else begin
            wr_ptr     <= wr_ptr + PTR_ONE;
            commit_ptr <= wr_ptr + PTR_ONE;
          end
        end else begin
          wr_ptr   <= wr_ptr + PTR_ONE;
          byte_idx <= byte_idx + IDX_ONE;
        end
      end
      DROP_CNT <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

`ifdef NULL_DROP_EN
  logic [7:0] hdr_b1;

  // Null-PID detection once header bytes 1 and 2 have been seen
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hdr_b1  <= '0;
      discard <= 1'b0;
    end else if (pkt_start) begin
      discard <= 1'b0;
    end else if (IN_ENA && in_active) begin
      if (byte_idx == IDX_W'(1)) hdr_b1 <= IN_DATA;
      if (byte_idx == IDX_W'(2) && ts_pid(hdr_b1, IN_DATA) == NULL_PID) discard <= 1'b1;
    end
  end
`else
  assign discard = 1'b0;
`endif

  // Committed-packet count; commit and read-completion together cancel out
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                       pkt_count <= '0;
    else if (do_commit && !rd_done) pkt_count <= pkt_count + PTR_ONE;
    else if (!do_commit && rd_done) pkt_count <= pkt_count - PTR_ONE;
  end

  // Output FSM. The output register loads from the source of the current
  // state; IDLE/GUARD load zeros. SEND_MAIN stays one extra cycle so the
  // RAM read stage drains before returning to IDLE.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= ST_IDLE;
      rd_ptr    <= '0;
      rd_cnt    <= '0;
      rd_vld    <= 1'b0;
      rd_first  <= 1'b0;
      TBL_START <= 1'b0;
      DATA_OUT  <= '0;
      ENA_OUT   <= 1'b0;
      PSYNC_OUT <= 1'b0;
    end else begin
      TBL_START <= 1'b0;
      rd_vld    <= 1'b0;
      rd_first  <= 1'b0;
      DATA_OUT  <= '0;
      ENA_OUT   <= 1'b0;
      PSYNC_OUT <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (TABLE_READY) begin
            TBL_START <= 1'b1;
            state     <= ST_SEND_TBL;
          end else if (pkt_count != '0) begin
            rd_cnt <= '0;
            state  <= ST_SEND_MAIN;
          end
        end
        ST_SEND_MAIN: begin
          if (rd_cnt < IDX_W'(PKT_LEN)) begin
            rd_ptr   <= rd_ptr + PTR_ONE;
            rd_vld   <= 1'b1;
            rd_first <= (rd_cnt == '0);
          end
          DATA_OUT  <= rd_vld ? rd_data : 8'h00;
          ENA_OUT   <= rd_vld;
          PSYNC_OUT <= rd_first;
          rd_cnt    <= rd_cnt + IDX_ONE;
          if (rd_done) state <= ST_IDLE;
        end
        ST_SEND_TBL: begin
          DATA_OUT  <= TBL_DATA;
          ENA_OUT   <= TBL_ENA;
          PSYNC_OUT <= TBL_PSYNC;
          if (TBL_SENT) state <= ST_GUARD;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
